// File: rtl/pwm_dac_stage.sv
// pwm_dac_stage: converts an 8-bit sample stream into 256-clock PWM periods.
// Duty reloads only at period boundaries; a stop request always finishes the
// current period (DRAIN) so the filtered output never sees a truncated pulse.
// Optional feature macro: AMP_SCALE_EN enables the 2-bit amplitude attenuator.
module pwm_dac_stage (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] wave_in,
    input  logic [1:0] amp,
    input  logic       en,
    output logic       pwm_out,
    output logic       period_done,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [7:0] duty, duty_nxt;
    logic       pwm_nxt, done_nxt;
    logic [7:0] scaled;
    logic       last;

`ifdef AMP_SCALE_EN
    // Attenuator: logical shifts, mute on 2'b11.
    always_comb begin
        scaled = wave_in;
        case (amp)
            2'b00:   scaled = wave_in;
            2'b01:   scaled = wave_in >> 1;
            2'b10:   scaled = wave_in >> 2;
            default: scaled = 8'd0;
        endcase
    end
`else
    // Attenuator compiled out; amp is kept on the port list for pin compatibility.
    logic unused_amp;
    assign unused_amp = ^amp;
    assign scaled     = wave_in;
`endif

    assign last = (cnt == 8'd255);
    assign busy = (state != IDLE);

    // Next-state and next-register values; defaults hold everything.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        duty_nxt  = duty;
        pwm_nxt   = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = 8'd0;
                if (en) begin
                    duty_nxt  = scaled;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                pwm_nxt = (cnt < duty);
                cnt_nxt = cnt + 8'd1;
                if (last) begin
                    done_nxt = 1'b1;
                    if (en) duty_nxt  = scaled;
                    else    state_nxt = IDLE;
                end else if (!en) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                pwm_nxt = (cnt < duty);
                cnt_nxt = cnt + 8'd1;
                if (last) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else if (en) begin
                    // Resume without reloading; the new duty waits for the boundary.
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    // State and datapath registers; reset clears outputs without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            duty        <= 8'd0;
            pwm_out     <= 1'b0;
            period_done <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            duty        <= duty_nxt;
            pwm_out     <= pwm_nxt;
            period_done <= done_nxt;
        end
    end

endmodule

// File: tb/tb_pwm_dac_stage.sv
// tb_pwm_dac_stage: directed bench for pwm_dac_stage. Measures high time,
// period length and idle cycles per PWM period against hand-computed values.
module tb_pwm_dac_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] wave_in;
    logic [1:0] amp;
    logic       en;
    logic       pwm_out, period_done, busy;

    int checks = 0;
    int errors = 0;
    int hi, len, idl;
    int pd_cnt, pwm_cnt, busy_cnt;

`ifdef AMP_SCALE_EN
    localparam int EXP_A1 = 100, EXP_A2 = 50, EXP_A3 = 0;
`else
    localparam int EXP_A1 = 200, EXP_A2 = 200, EXP_A3 = 200;
`endif

    pwm_dac_stage dut (
        .clk(clk), .rst(rst), .wave_in(wave_in), .amp(amp), .en(en),
        .pwm_out(pwm_out), .period_done(period_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Sample on falling edges until period_done is seen. Sample n of a period
    // that follows a period_done sample corresponds to cnt==n. Optional
    // stimulus changes are applied after sampling at the given indices.
    task automatic measure(input int chg_at, input logic [7:0] nw, input logic [1:0] na,
                           input int off_at, input int on_at,
                           output int highs, output int plen, output int idles);
        highs = 0; plen = 0; idles = 0;
        for (int n = 1; n <= 600; n++) begin
            @(negedge clk);
            plen = n;
            if (pwm_out) highs++;
            if (!busy)   idles++;
            if (period_done) break;
            if (n == chg_at) begin wave_in = nw; amp = na; end
            if (n == off_at) en = 1'b0;
            if (n == on_at)  en = 1'b1;
        end
        chk("period_end", int'(period_done), 1);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; wave_in = 8'd0; amp = 2'b00;
        repeat (3) @(negedge clk);
        chk("rst_pwm", int'(pwm_out), 0);
        chk("rst_done", int'(period_done), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", int'(busy), 0);

        // Steady duty 64
        wave_in = 8'd64; en = 1'b1;
        measure(-1, 8'd0, 2'b00, -1, -1, hi, len, idl);
        chk("first_hi64", hi, 64);
        chk("first_len", len, 257);
        measure(-1, 8'd0, 2'b00, -1, -1, hi, len, idl);
        chk("hi64", hi, 64);
        chk("len64", len, 256);
        chk("idle64", idl, 0);

        // Mid-period sample change is deferred to the next period
        measure(10, 8'd200, 2'b00, -1, -1, hi, len, idl);
        chk("chg_cur64", hi, 64);
        measure(10, 8'd200, 2'b01, -1, -1, hi, len, idl);
        chk("chg_nxt200", hi, 200);

        // Attenuation
        measure(10, 8'd200, 2'b10, -1, -1, hi, len, idl);
        chk("amp01", hi, EXP_A1);
        measure(10, 8'd200, 2'b11, -1, -1, hi, len, idl);
        chk("amp10", hi, EXP_A2);
        measure(10, 8'd128, 2'b00, -1, -1, hi, len, idl);
        chk("amp11", hi, EXP_A3);
        chk("amp11_busy", idl, 0);

        // Duty 128 then the 255 boundary
        measure(10, 8'd255, 2'b00, -1, -1, hi, len, idl);
        chk("hi128", hi, 128);
        measure(10, 8'd128, 2'b00, -1, -1, hi, len, idl);
        chk("hi255", hi, 255);
        chk("len255", len, 256);

        // Stop at cnt=50 with duty 128: period completes, then quiet
        measure(-1, 8'd0, 2'b00, 50, -1, hi, len, idl);
        chk("stop_hi", hi, 128);
        chk("stop_len", len, 256);
        chk("stop_idle", idl, 1);
        chk("stop_busy", int'(busy), 0);
        pd_cnt = 0; pwm_cnt = 0; busy_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (period_done) pd_cnt++;
            if (pwm_out)     pwm_cnt++;
            if (busy)        busy_cnt++;
        end
        chk("quiet_done", pd_cnt, 0);
        chk("quiet_pwm", pwm_cnt, 0);
        chk("quiet_busy", busy_cnt, 0);

        // Drain re-entry at cnt=200: no gap, no early reload
        wave_in = 8'd100; en = 1'b1;
        measure(-1, 8'd0, 2'b00, -1, -1, hi, len, idl);
        chk("d_first_hi", hi, 100);
        measure(10, 8'd30, 2'b00, 10, 200, hi, len, idl);
        chk("drain_hi", hi, 100);
        chk("drain_len", len, 256);
        chk("drain_idle", idl, 0);
        measure(10, 8'd200, 2'b00, -1, -1, hi, len, idl);
        chk("drain_reload", hi, 30);
        chk("drain_len2", len, 256);

        // Asynchronous reset mid-period at cnt=100 with pwm high
        for (int i = 0; i < 100; i++) @(negedge clk);
        chk("pre_rst_pwm", int'(pwm_out), 1);
        chk("pre_rst_busy", int'(busy), 1);
        en = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_pwm", int'(pwm_out), 0);
        chk("async_done", int'(period_done), 0);
        chk("async_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_pwm", int'(pwm_out), 0);
        en = 1'b1;
        measure(-1, 8'd0, 2'b00, -1, -1, hi, len, idl);
        chk("post_rst_hi", hi, 200);
        chk("post_rst_len", len, 257);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
